hilo_unit: RTL

Sequencing and result-holding stage around the combinational Booth multiplier. It latches operands on a start request and drives them to the multiplier. It captures the 64-bit product into the HI/LO register pair, or runs a 32-iteration signed restoring divide into the same pair. HI/LO feed the datapath bus for move-from-HI/LO instructions and can be loaded from the bus for move-to-HI/LO.

---
 rtl/hilo_unit_pkg.sv | 20 ++
 rtl/hilo_unit_div_step.sv | 32 +++
 rtl/hilo_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg
//   Shared definitions for the HI/LO sequencing stage: default datapath
//   width, operation encoding, FSM state type and divide iteration count.
package hilo_unit_pkg;

   localparam int unsigned HILO_WIDTH = 32;
   localparam int unsigned DIV_STEPS  = 32;
   localparam int unsigned ITER_W     = $clog2(DIV_STEPS);

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/hilo_unit_div_step.sv
// hilo_unit_div_step
//   One combinational restoring-division step on unsigned magnitudes.
//   Ports:
//     rem_in   partial remainder (always < divisor)
//     dvd_bit  next dividend bit shifted in
//     divisor  divisor magnitude (non-zero)
//     rem_out  next partial remainder
//     q_bit    quotient bit produced by this step
module hilo_unit_div_step
   import hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = HILO_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // One extra bit: the shifted remainder can reach 2*divisor-1.
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   always_comb begin
      trial   = {rem_in, dvd_bit};
      diff    = trial - {1'b0, divisor};
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit
//   Sequencing and result-holding stage around the external Booth
//   multiplier. Latches operands on start, captures the 64-bit product or
//   runs a 32-step signed restoring divide into the HI/LO pair, and lets
//   the datapath bus read/load HI and LO.
//   Ports:
//     clock, reset         clock; async active-high reset
//     start, op            request and operation (0 = MUL, 1 = DIV)
//     Ra, Rb               operands
//     mul_a, mul_b         latched operands to the multiplier
//     mul_hi, mul_lo       product halves from the multiplier
//     bus_in               bus value for move-to-HI/LO
//     hi_load, lo_load     load bus_in into HI / LO
//     busy                 operation in progress (decoded from state)
//     done                 one-cycle result pulse
//     div_by_zero          last DIV had a zero divisor
//     HI, LO               result registers
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = HILO_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic [WIDTH-1:0] mul_hi,
   input  logic [WIDTH-1:0] mul_lo,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             hi_load,
   input  logic             lo_load,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   state_t            state;
   logic [WIDTH-1:0]  dvd;      // dividend magnitude, shifts out MSB-first while quotient shifts in
   logic [WIDTH-1:0]  dvs;      // divisor magnitude
   logic [WIDTH-1:0]  rem;
   logic [ITER_W-1:0] iter;

   logic [WIDTH-1:0]  step_rem;
   logic              step_q;
   logic [WIDTH-1:0]  quo_next;
   logic [WIDTH-1:0]  quo_final;
   logic [WIDTH-1:0]  rem_final;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   hilo_unit_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .dvd_bit (dvd[WIDTH-1]),
      .divisor (dvs),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Sign fix-up uses the latched raw operands; the most-negative quotient
   // wraps back to itself, which is the intended overflow result.
   always_comb begin
      quo_next  = {dvd[WIDTH-2:0], step_q};
      quo_final = (mul_a[WIDTH-1] ^ mul_b[WIDTH-1]) ? -quo_next : quo_next;
      rem_final = mul_a[WIDTH-1] ? -step_rem : step_rem;
      busy      = (state == ST_MUL) || (state == ST_DIV);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         mul_a       <= '0;
         mul_b       <= '0;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         iter        <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         HI          <= '0;
         LO          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mul_a       <= Ra;
                  mul_b       <= Rb;
                  dvd         <= mag(Ra);
                  dvs         <= mag(Rb);
                  rem         <= '0;
                  iter        <= '0;
                  div_by_zero <= 1'b0;
                  state       <= (op == OP_DIV) ? ST_DIV : ST_MUL;
               end else begin
                  if (hi_load) HI <= bus_in;
                  if (lo_load) LO <= bus_in;
                  state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               HI    <= mul_hi;
               LO    <= mul_lo;
               done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_DIV: begin
               if (mul_b == '0) begin
                  HI          <= mul_a;
                  LO          <= '1;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  rem  <= step_rem;
                  dvd  <= quo_next;
                  iter <= iter + 1'b1;
                  if (iter == ITER_W'(DIV_STEPS - 1)) begin
                     HI    <= rem_final;
                     LO    <= quo_final;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
